rif_arbiter: RTL and testbench
==============================

RIF_ARBITER -- requirements
Module: rif_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 12: register address width.
REQ-002 Parameter DATA_WIDTH, default 32: register data width.
REQ-003 Parameter BYTE_COUNT, default DATA_WIDTH/8: write strobe width.
REQ-004 aclk  input  1  single clock; all logic rising-edge.
REQ-005 aresetn  input  1  reset, asynchronous assert, active-low.
REQ-006 mN_req  input  1  requester N (N=0,1) access request, level.
REQ-007 mN_we  input  1  requester N direction: 1 write, 0 read.
REQ-008 mN_addr  input  ADDR_WIDTH  requester N address.
REQ-009 mN_wdata  input  DATA_WIDTH  requester N write data.
REQ-010 mN_wstrb  input  BYTE_COUNT  requester N byte strobes.
REQ-011 mN_done  output  1  one-cycle completion pulse to requester N.
REQ-012 mN_err  output  1  completion status, valid with mN_done: 1 = target rejected access.
REQ-013 mN_rdata  output  DATA_WIDTH  read data, valid with mN_done on reads.
REQ-014 rif_waddr, rif_raddr  output  ADDR_WIDTH  granted address, both driven from one latched register.
REQ-015 rif_wr_req / rif_rd_req  output  1  single-cycle write / read strobe to register file.
REQ-016 rif_wdata  output  DATA_WIDTH; rif_wstrb  output  BYTE_COUNT  latched write payload.
REQ-017 rif_wvalid / rif_rvalid  input  1  register file accepts address, same cycle as strobe.
REQ-018 rif_rdata  input  DATA_WIDTH  register file read data, same cycle as rif_rd_req.

Function
REQ-019 FSM states IDLE, ISSUE, RESP; IDLE->ISSUE when any mN_req=1; ISSUE->RESP unconditionally; RESP->IDLE unconditionally.
REQ-020 In IDLE with requests, arbiter selects winner (REQ-033/034), latches winner's we, addr, wdata, wstrb and index.
REQ-021 In ISSUE, exactly one of rif_wr_req (we=1) or rif_rd_req (we=0) is 1 for exactly one cycle; other strobe 0.
REQ-022 In ISSUE, arbiter samples rif_wvalid (write) or rif_rvalid and rif_rdata (read) into response registers.
REQ-023 In RESP, winner's mN_done=1 for one cycle; mN_err = ~sampled valid; mN_rdata = sampled data on read, 0 on write.
REQ-024 Non-winner done, err always 0; rdata outputs hold 0 except during own done cycle.
REQ-025 Latency: req sampled in IDLE cycle T -> rif strobe cycle T+1 -> mN_done cycle T+2; maximum throughput one access per 3 cycles.
REQ-026 mN_req still 1 in IDLE after own done counts as new request.
REQ-027 Deassertion of mN_req after grant does not abort; transaction completes with done pulse.
REQ-028 Changes to mN_addr/wdata/wstrb/we after grant do not affect in-flight access.
REQ-029 Both requests simultaneously in IDLE: exactly one granted; loser remains pending, granted next IDLE if still asserted.
REQ-030 Last-grant register updated in RESP to winner index.

Reset
REQ-031 aresetn=0 forces IDLE, all outputs 0, latched addr/data/strb 0, last-grant = 1, immediately and asynchronously.
REQ-032 Reset during ISSUE or RESP abandons transaction; no done pulse issued after reset release.

Configuration
REQ-033 Macro RIF_ARB_RR_EN defined: round-robin; on simultaneous requests, port other than last-grant wins; after reset port 0 wins first tie.
REQ-034 RIF_ARB_RR_EN undefined: fixed priority, m0 always wins ties; last-grant register still present but unused for selection.

Verification
REQ-035 Single m0 write addr 0x010 data 0xDEADBEEF strb 0xF, rif_wvalid=1 -> rif_wr_req one cycle at T+1 with those values; m0_done=1, m0_err=0 at T+2.
REQ-036 m1 read addr 0x024, rif_rvalid=1, rif_rdata=0x12345678 -> rif_rd_req at T+1; m1_done=1, m1_rdata=0x12345678, m1_err=0 at T+2.
REQ-037 m0 read with rif_rvalid=0 -> m0_done=1, m0_err=1, m0_rdata=0x0.
REQ-038 Both req held high 12 cycles from reset, RR_EN defined -> grants alternate 0,1,0,1; undefined -> m0 granted all four, m1 starved.
REQ-039 m0 request granted, m0_req dropped and m0_addr changed to 0x0FF at T+1 -> rif address still original, m0_done still pulses at T+2.
REQ-040 aresetn asserted in ISSUE cycle -> all outputs 0 immediately; no mN_done after release; next request served with normal T+2 latency.

Source files
------------

// File: rtl/rif_arbiter_if.sv
// Bundle of the two requester ports and the register-file port of rif_arbiter.
// The slave modport is the arbiter's view; master is the view of the surrounding logic.
interface rif_arbiter_if #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32,
   parameter int BYTE_COUNT = DATA_WIDTH / 8
);
   logic                  m0_req;
   logic                  m0_we;
   logic [ADDR_WIDTH-1:0] m0_addr;
   logic [DATA_WIDTH-1:0] m0_wdata;
   logic [BYTE_COUNT-1:0] m0_wstrb;
   logic                  m0_done;
   logic                  m0_err;
   logic [DATA_WIDTH-1:0] m0_rdata;

   logic                  m1_req;
   logic                  m1_we;
   logic [ADDR_WIDTH-1:0] m1_addr;
   logic [DATA_WIDTH-1:0] m1_wdata;
   logic [BYTE_COUNT-1:0] m1_wstrb;
   logic                  m1_done;
   logic                  m1_err;
   logic [DATA_WIDTH-1:0] m1_rdata;

   logic [ADDR_WIDTH-1:0] rif_waddr;
   logic [ADDR_WIDTH-1:0] rif_raddr;
   logic                  rif_wr_req;
   logic                  rif_rd_req;
   logic [DATA_WIDTH-1:0] rif_wdata;
   logic [BYTE_COUNT-1:0] rif_wstrb;
   logic                  rif_wvalid;
   logic                  rif_rvalid;
   logic [DATA_WIDTH-1:0] rif_rdata;

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
      output m0_done, m0_err, m0_rdata,
      input  m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
      output m1_done, m1_err, m1_rdata,
      output rif_waddr, rif_raddr, rif_wr_req, rif_rd_req, rif_wdata, rif_wstrb,
      input  rif_wvalid, rif_rvalid, rif_rdata
   );

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata, m0_wstrb,
      input  m0_done, m0_err, m0_rdata,
      output m1_req, m1_we, m1_addr, m1_wdata, m1_wstrb,
      input  m1_done, m1_err, m1_rdata,
      input  rif_waddr, rif_raddr, rif_wr_req, rif_rd_req, rif_wdata, rif_wstrb,
      output rif_wvalid, rif_rvalid, rif_rdata
   );
endinterface

// File: rtl/rif_arbiter.sv
// Two-requester arbiter in front of a single-cycle register file; IDLE -> ISSUE -> RESP per access.
// Define RIF_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 has fixed priority.
module rif_arbiter #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32,
   parameter int BYTE_COUNT = DATA_WIDTH / 8
) (
   input  logic       aclk,
   input  logic       aresetn,
   rif_arbiter_if.slave bus,
   output logic [1:0] debug_state,
   output logic       debug_last_grant
);

   // Handshake: mN_req is a level request, sampled only in IDLE; the access is
   // committed once sampled and is closed by a single-cycle mN_done (status in
   // mN_err, read data in mN_rdata). The register file must answer with
   // rif_wvalid/rif_rvalid (and rif_rdata) in the same cycle as the strobe.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   state_t                state;
   logic                  idx_q;
   logic                  last_q;
   logic                  we_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [BYTE_COUNT-1:0] wstrb_q;
   logic                  wr_req_q;
   logic                  rd_req_q;
   logic                  done0_q, done1_q;
   logic                  err0_q, err1_q;
   logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

   logic                  any_req;
   logic                  pick;
   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic [BYTE_COUNT-1:0] sel_wstrb;
   logic                  rsp_ok;
   logic [DATA_WIDTH-1:0] rsp_data;

   assign any_req = bus.m0_req | bus.m1_req;

   always_comb begin
      pick = 1'b0;
      if (bus.m0_req && bus.m1_req) begin
`ifdef RIF_ARB_RR_EN
         pick = ~last_q;
`else
         pick = 1'b0;
`endif
      end else if (bus.m1_req) begin
         pick = 1'b1;
      end
   end

   always_comb begin
      sel_we    = pick ? bus.m1_we    : bus.m0_we;
      sel_addr  = pick ? bus.m1_addr  : bus.m0_addr;
      sel_wdata = pick ? bus.m1_wdata : bus.m0_wdata;
      sel_wstrb = pick ? bus.m1_wstrb : bus.m0_wstrb;
   end

   // Rejected reads return zero rather than whatever the register file drove.
   always_comb begin
      rsp_ok   = we_q ? bus.rif_wvalid : bus.rif_rvalid;
      rsp_data = (!we_q && bus.rif_rvalid) ? bus.rif_rdata : '0;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state    <= IDLE;
         idx_q    <= 1'b0;
         last_q   <= 1'b1;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         wr_req_q <= 1'b0;
         rd_req_q <= 1'b0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         err0_q   <= 1'b0;
         err1_q   <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         wr_req_q <= 1'b0;
         rd_req_q <= 1'b0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         err0_q   <= 1'b0;
         err1_q   <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  idx_q    <= pick;
                  we_q     <= sel_we;
                  addr_q   <= sel_addr;
                  wdata_q  <= sel_wdata;
                  wstrb_q  <= sel_wstrb;
                  wr_req_q <= sel_we;
                  rd_req_q <= ~sel_we;
                  state    <= ISSUE;
               end
            end
            ISSUE: begin
               if (idx_q) begin
                  done1_q  <= 1'b1;
                  err1_q   <= ~rsp_ok;
                  rdata1_q <= rsp_data;
               end else begin
                  done0_q  <= 1'b1;
                  err0_q   <= ~rsp_ok;
                  rdata0_q <= rsp_data;
               end
               state <= RESP;
            end
            RESP: begin
               last_q <= idx_q;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.rif_waddr  = addr_q;
   assign bus.rif_raddr  = addr_q;
   assign bus.rif_wr_req = wr_req_q;
   assign bus.rif_rd_req = rd_req_q;
   assign bus.rif_wdata  = wdata_q;
   assign bus.rif_wstrb  = wstrb_q;
   assign bus.m0_done    = done0_q;
   assign bus.m0_err     = err0_q;
   assign bus.m0_rdata   = rdata0_q;
   assign bus.m1_done    = done1_q;
   assign bus.m1_err     = err1_q;
   assign bus.m1_rdata   = rdata1_q;

   assign debug_state      = state;
   assign debug_last_grant = last_q;

endmodule

// File: tb/tb_rif_arbiter.sv
// Directed bench for rif_arbiter: reset values, writes, reads, rejection, tie-breaking,
// request withdrawal and reset in mid-transaction. Tie expectations follow RIF_ARB_RR_EN.
module tb_rif_arbiter;

   logic       aclk;
   logic       aresetn;
   logic [1:0] debug_state;
   logic       debug_last_grant;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   rif_arbiter_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .BYTE_COUNT(4)) bus ();

   rif_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .BYTE_COUNT(4)) dut (
      .aclk             (aclk),
      .aresetn          (aresetn),
      .bus              (bus),
      .debug_state      (debug_state),
      .debug_last_grant (debug_last_grant)
   );

   // clock / reset
   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) begin
         passes++;
      end else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_idle();
      bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_wstrb = '0;
      bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_wstrb = '0;
      bus.rif_wvalid = 1'b0; bus.rif_rvalid = 1'b0; bus.rif_rdata = '0;
   endtask

   task automatic do_reset();
      #2 aresetn = 1'b0;
      step();
      step();
      aresetn = 1'b1;
      step();
   endtask

   logic       grant_idx [4];
   int         n_grants;
   int         n_m1;
   logic [3:0] exp_grants;

   initial begin
      aresetn = 1'b1;
      drive_idle();
      #2 aresetn = 1'b0;
      #1;
      chk("reset_state",      {30'd0, debug_state}, 32'd0);
      chk("reset_last_grant", {31'd0, debug_last_grant}, 32'd1);
      chk("reset_wr_req",     {31'd0, bus.rif_wr_req}, 32'd0);
      chk("reset_waddr",      {20'd0, bus.rif_waddr}, 32'd0);
      chk("reset_m0_done",    {31'd0, bus.m0_done}, 32'd0);
      step();
      aresetn = 1'b1;
      step();

      // single m0 write
      bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 12'h010;
      bus.m0_wdata = 32'hDEADBEEF; bus.m0_wstrb = 4'hF; bus.rif_wvalid = 1'b1;
      step();
      bus.m0_req = 1'b0;
      chk("wr_t1_state",  {30'd0, debug_state}, 32'd1);
      chk("wr_t1_wr_req", {31'd0, bus.rif_wr_req}, 32'd1);
      chk("wr_t1_rd_req", {31'd0, bus.rif_rd_req}, 32'd0);
      chk("wr_t1_waddr",  {20'd0, bus.rif_waddr}, 32'h010);
      chk("wr_t1_raddr",  {20'd0, bus.rif_raddr}, 32'h010);
      chk("wr_t1_wdata",  bus.rif_wdata, 32'hDEADBEEF);
      chk("wr_t1_wstrb",  {28'd0, bus.rif_wstrb}, 32'hF);
      step();
      chk("wr_t2_m0_done", {31'd0, bus.m0_done}, 32'd1);
      chk("wr_t2_m0_err",  {31'd0, bus.m0_err}, 32'd0);
      chk("wr_t2_m0_rdata", bus.m0_rdata, 32'd0);
      chk("wr_t2_m1_done", {31'd0, bus.m1_done}, 32'd0);
      chk("wr_t2_wr_req",  {31'd0, bus.rif_wr_req}, 32'd0);
      step();
      chk("wr_t3_m0_done", {31'd0, bus.m0_done}, 32'd0);
      chk("wr_t3_last",    {31'd0, debug_last_grant}, 32'd0);
      drive_idle();

      // single m1 read
      bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 12'h024;
      bus.rif_rvalid = 1'b1; bus.rif_rdata = 32'h12345678;
      step();
      bus.m1_req = 1'b0;
      chk("rd_t1_rd_req", {31'd0, bus.rif_rd_req}, 32'd1);
      chk("rd_t1_wr_req", {31'd0, bus.rif_wr_req}, 32'd0);
      chk("rd_t1_raddr",  {20'd0, bus.rif_raddr}, 32'h024);
      step();
      chk("rd_t2_m1_done",  {31'd0, bus.m1_done}, 32'd1);
      chk("rd_t2_m1_rdata", bus.m1_rdata, 32'h12345678);
      chk("rd_t2_m1_err",   {31'd0, bus.m1_err}, 32'd0);
      chk("rd_t2_m0_done",  {31'd0, bus.m0_done}, 32'd0);
      step();
      chk("rd_t3_m1_rdata", bus.m1_rdata, 32'd0);
      chk("rd_t3_last",     {31'd0, debug_last_grant}, 32'd1);
      drive_idle();

      // m0 read rejected by register file
      bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 12'h030;
      bus.rif_rvalid = 1'b0; bus.rif_rdata = 32'hA5A5A5A5;
      step();
      bus.m0_req = 1'b0;
      step();
      chk("rej_m0_done",  {31'd0, bus.m0_done}, 32'd1);
      chk("rej_m0_err",   {31'd0, bus.m0_err}, 32'd1);
      chk("rej_m0_rdata", bus.m0_rdata, 32'd0);
      step();
      drive_idle();

      // request withdrawn and payload changed after grant
      bus.m0_req = 1'b1; bus.m0_we = 1'b1; bus.m0_addr = 12'h100;
      bus.m0_wdata = 32'h0000_1111; bus.m0_wstrb = 4'h3; bus.rif_wvalid = 1'b1;
      step();
      bus.m0_req = 1'b0; bus.m0_addr = 12'h0FF; bus.m0_wdata = 32'h2222_2222; bus.m0_wstrb = 4'hC;
      #2;
      chk("drop_t1_waddr", {20'd0, bus.rif_waddr}, 32'h100);
      chk("drop_t1_wdata", bus.rif_wdata, 32'h0000_1111);
      chk("drop_t1_wstrb", {28'd0, bus.rif_wstrb}, 32'h3);
      step();
      chk("drop_t2_m0_done", {31'd0, bus.m0_done}, 32'd1);
      chk("drop_t2_waddr",   {20'd0, bus.rif_waddr}, 32'h100);
      step();
      step();
      chk("drop_no_regrant", {30'd0, debug_state}, 32'd0);
      drive_idle();

      // both requesters held high from reset for 12 cycles
      do_reset();
      bus.m0_req = 1'b1; bus.m0_addr = 12'h001;
      bus.m1_req = 1'b1; bus.m1_addr = 12'h002;
      bus.rif_rvalid = 1'b1;
      n_grants = 0;
      n_m1 = 0;
      for (int c = 0; c < 12; c++) begin
         step();
         if ((bus.m0_done || bus.m1_done) && n_grants < 4) begin
            grant_idx[n_grants] = bus.m1_done;
            n_grants++;
         end
         if (bus.m1_done) n_m1++;
      end
      drive_idle();
`ifdef RIF_ARB_RR_EN
      exp_grants = 4'b1010;
      chk("tie_m1_count", n_m1, 32'd2);
`else
      exp_grants = 4'b0000;
      chk("tie_m1_count", n_m1, 32'd0);
`endif
      chk("tie_grant_count", n_grants, 32'd4);
      for (int g = 0; g < 4; g++) begin
         if (g < n_grants)
            chk($sformatf("tie_grant_%0d", g), {31'd0, grant_idx[g]}, {31'd0, exp_grants[g]});
      end
      step();
      step();

      // reset asserted while the access is in ISSUE
      bus.m1_req = 1'b1; bus.m1_we = 1'b1; bus.m1_addr = 12'h0AB;
      bus.m1_wdata = 32'hCAFE_F00D; bus.m1_wstrb = 4'hF; bus.rif_wvalid = 1'b1;
      step();
      chk("rst_issue_before", {30'd0, debug_state}, 32'd1);
      bus.m1_req = 1'b0;
      #2 aresetn = 1'b0;
      #1;
      chk("rst_issue_state",  {30'd0, debug_state}, 32'd0);
      chk("rst_issue_wr_req", {31'd0, bus.rif_wr_req}, 32'd0);
      chk("rst_issue_waddr",  {20'd0, bus.rif_waddr}, 32'd0);
      chk("rst_issue_wdata",  bus.rif_wdata, 32'd0);
      step();
      aresetn = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         chk($sformatf("rst_no_done_%0d", c), {30'd0, bus.m1_done, bus.m0_done}, 32'd0);
      end
      drive_idle();
      bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 12'h044;
      bus.rif_rvalid = 1'b1; bus.rif_rdata = 32'h0BAD_CAFE;
      step();
      bus.m0_req = 1'b0;
      chk("post_rst_rd_req", {31'd0, bus.rif_rd_req}, 32'd1);
      step();
      chk("post_rst_m0_done",  {31'd0, bus.m0_done}, 32'd1);
      chk("post_rst_m0_rdata", bus.m0_rdata, 32'h0BAD_CAFE);
      step();
      drive_idle();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
